ebpc_stream_arbiter: RTL and testbench
======================================

Name: ebpc_stream_arbiter

Overview:
Merges the two encoder output word streams, BPC (bit-plane coder) and ZNZ (zero/non-zero RLE), onto the single output port of the EBPC encoder.
- Arbitration is round-robin with bounded bursts.
- Every output word carries a source tag.
- Per-source word counts are kept for the current frame.
- On flush, both sources are drained and the frame is closed with a trailer beat that carries last_o.

Parameters:
DATA_W, 8, word width of both inputs and the output
MAX_BURST, 4, maximum consecutive words granted to one source while the other is requesting (>=1)
CNT_W, 16, width of the per-source word counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
bpc_data_i  in  DATA_W  BPC word
bpc_vld_i  in  1  BPC word valid
bpc_rdy_o  out  1  BPC word accepted
bpc_idle_i  in  1  BPC coder has no buffered state
znz_data_i  in  DATA_W  ZNZ word
znz_vld_i  in  1  ZNZ word valid
znz_rdy_o  out  1  ZNZ word accepted
znz_idle_i  in  1  ZNZ coder has no buffered state
flush_i  in  1  single-cycle request to close the current frame
data_o  out  DATA_W  output word
src_o  out  2  output word source: 00 BPC, 01 ZNZ, 10 trailer
last_o  out  1  marks the trailer beat
vld_o  out  1  output valid
rdy_i  in  1  output ready
bpc_cnt_o  out  CNT_W  BPC words emitted in the current frame
znz_cnt_o  out  CNT_W  ZNZ words emitted in the current frame
idle_o  out  1  arbiter and both sources quiescent

Behaviour:
Reset values:
- vld_o=0, data_o=0, src_o=0, last_o=0, bpc_cnt_o=0, znz_cnt_o=0.
- FSM in RUN, flush_pending=0, burst counter 0.
- Round-robin pointer = ZNZ-last, so BPC wins the first tie.

Handshake and latency:
- A single output register holds {data, src, last}.
- The register loads when empty or when vld_o && rdy_i in the same cycle.
- Latency is exactly 1 cycle from input acceptance to vld_o.
- Full throughput: one word per cycle when rdy_i stays high.
- At most one of bpc_rdy_o / znz_rdy_o is high in any cycle.
- rdy_o is high only for the granted source, and only when the output register can load.
- An input word transfers when its vld && rdy are both high.
- vld_o, data_o, src_o and last_o hold stable while vld_o && !rdy_i.

Arbitration (combinational grant, registered pointer and burst counter):
- Only one source valid: grant it.
- Both valid and the burst counter of the current owner < MAX_BURST: keep the current owner.
- Both valid and the owner has used MAX_BURST words: grant the other source.
- Both valid with no owner: grant the source opposite the round-robin pointer.
- The burst counter increments on each accepted word of the same source.
- The burst counter resets to 1 on a source switch.
- The burst counter resets to 0 in any cycle where the owner transfers no word.

Counters:
- The per-source counter increments on each accepted word of that source.
- Counters saturate at 2^CNT_W-1.
- Both counters clear in the cycle the trailer beat is accepted at the output.

FSM:
- RUN: normal merging. flush_i sets flush_pending and the state moves to DRAIN.
- DRAIN: merging continues. A flush_i arriving in DRAIN or TRAIL is absorbed (no second trailer).
- DRAIN -> TRAIL when all of the following hold: bpc_idle_i && znz_idle_i && !bpc_vld_i && !znz_vld_i, and the output register is empty or being consumed this cycle.
- TRAIL: the output register loads data=0, src=10, last=1. Both input rdy are held low.
- TRAIL -> RUN on trailer acceptance (vld_o && rdy_i). flush_pending clears at the same time.
- flush_i while completely idle still produces one trailer beat (empty frame).
- flush_i in the same cycle as an input transfer: that word is emitted before the trailer.

idle_o:
- Asserted iff all of the following hold: state RUN, !vld_o, !flush_pending, both idle_i high, and both input vld low.

Reset mid-frame:
- Pending output is dropped.
- Counters, pointer and FSM return to their reset values immediately (asynchronously).

Test Plan:
- BPC-only stream of 10 words 0x01..0x0A, rdy_i=1: output shows the same words in order, src_o=00, 1-cycle latency, bpc_cnt_o=10, znz_cnt_o=0.
- Both sources continuously valid, MAX_BURST=4: src_o pattern is BPC x4, ZNZ x4, BPC x4, ...; first beat after reset is BPC.
- Random rdy_i backpressure (50%) with both sources valid: no word lost or duplicated, and data_o is stable while stalled; scoreboard matches each source's order.
- 3 BPC + 2 ZNZ words, then flush_i while ZNZ is still valid and znz_idle_i=0 for 5 cycles: trailer (data 0, src 10, last_o=1) appears only after the last ZNZ word; counters read 3/2 before trailer acceptance and 0/0 afterwards.
- flush_i pulses on two consecutive cycles with no data: exactly one trailer beat is emitted; idle_o returns to 1 the cycle after its acceptance.
- rst_ni asserted while vld_o=1 and in DRAIN: vld_o drops immediately; after release the FSM is in RUN, counters are 0, and the next tie goes to BPC.

Source files
------------

// File: rtl/ebpc_stream_arbiter_if.sv
// Word-stream bundle between the EBPC coders and the encoder output port.
// The slave modport is the arbiter's view; master is the environment's view.
interface ebpc_stream_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] bpc_data_i;
  logic              bpc_vld_i;
  logic              bpc_rdy_o;
  logic              bpc_idle_i;
  logic [DATA_W-1:0] znz_data_i;
  logic              znz_vld_i;
  logic              znz_rdy_o;
  logic              znz_idle_i;
  logic              flush_i;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        src_o;
  logic              last_o;
  logic              vld_o;
  logic              rdy_i;
  logic [CNT_W-1:0]  bpc_cnt_o;
  logic [CNT_W-1:0]  znz_cnt_o;
  logic              idle_o;

  modport slave (
    input  bpc_data_i, bpc_vld_i, bpc_idle_i,
    input  znz_data_i, znz_vld_i, znz_idle_i,
    input  flush_i, rdy_i,
    output bpc_rdy_o, znz_rdy_o,
    output data_o, src_o, last_o, vld_o,
    output bpc_cnt_o, znz_cnt_o, idle_o
  );

  modport master (
    output bpc_data_i, bpc_vld_i, bpc_idle_i,
    output znz_data_i, znz_vld_i, znz_idle_i,
    output flush_i, rdy_i,
    input  bpc_rdy_o, znz_rdy_o,
    input  data_o, src_o, last_o, vld_o,
    input  bpc_cnt_o, znz_cnt_o, idle_o
  );
endinterface

// File: rtl/ebpc_stream_arbiter.sv
// Round-robin, burst-bounded merge of the BPC and ZNZ word streams onto one
// tagged output; flush drains both coders and closes the frame with a trailer.
module ebpc_stream_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ebpc_stream_arbiter_if.slave bus
);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [1:0] SRC_BPC = 2'b00;
  localparam logic [1:0] SRC_ZNZ = 2'b01;
  localparam logic [1:0] SRC_TRL = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TRAIL} state_e;

  state_e              state_q, state_d;
  logic                flush_pend_q, flush_pend_d;
  logic                ptr_q, ptr_d;          // last served source: 0 BPC, 1 ZNZ
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          src_q, src_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    bpc_cnt_q, bpc_cnt_d;
  logic [CNT_W-1:0]    znz_cnt_q, znz_cnt_d;

  logic load_ok, grant_any, grant_znz;
  logic bpc_xfer, znz_xfer, out_xfer, trl_xfer, drain_done;

  assign load_ok    = !vld_q || bus.rdy_i;
  assign out_xfer   = vld_q && bus.rdy_i;
  assign trl_xfer   = out_xfer && last_q;
  assign drain_done = bus.bpc_idle_i && bus.znz_idle_i && !bus.bpc_vld_i &&
                      !bus.znz_vld_i && load_ok;

  // Grant: a running owner keeps the port until its burst is used up.
  always_comb begin
    grant_any = 1'b0;
    grant_znz = 1'b0;
    if (state_q != ST_TRAIL) begin
      if (bus.bpc_vld_i && bus.znz_vld_i) begin
        grant_any = 1'b1;
        if ((burst_q != '0) && (burst_q < BURST_MAX)) grant_znz = ptr_q;
        else                                          grant_znz = !ptr_q;
      end else if (bus.bpc_vld_i) begin
        grant_any = 1'b1;
      end else if (bus.znz_vld_i) begin
        grant_any = 1'b1;
        grant_znz = 1'b1;
      end
    end
  end

  assign bus.bpc_rdy_o = grant_any && !grant_znz && load_ok;
  assign bus.znz_rdy_o = grant_any && grant_znz && load_ok;
  assign bpc_xfer      = bus.bpc_vld_i && bus.bpc_rdy_o;
  assign znz_xfer      = bus.znz_vld_i && bus.znz_rdy_o;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    ptr_d        = ptr_q;
    burst_d      = '0;
    vld_d        = vld_q;
    data_d       = data_q;
    src_d        = src_q;
    last_d       = last_q;
    bpc_cnt_d    = bpc_cnt_q;
    znz_cnt_d    = znz_cnt_q;

    if (out_xfer) vld_d = 1'b0;

    // Output register: accepted word, else the trailer once in TRAIL.
    if (bpc_xfer || znz_xfer) begin
      vld_d  = 1'b1;
      data_d = znz_xfer ? bus.znz_data_i : bus.bpc_data_i;
      src_d  = znz_xfer ? SRC_ZNZ : SRC_BPC;
      last_d = 1'b0;
    end else if ((state_q == ST_TRAIL) && !vld_q) begin
      vld_d  = 1'b1;
      data_d = '0;
      src_d  = SRC_TRL;
      last_d = 1'b1;
    end

    if (bpc_xfer || znz_xfer) begin
      if (znz_xfer == ptr_q) burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
      else                   burst_d = BURST_W'(1);
      ptr_d = znz_xfer;
    end

    if (trl_xfer) begin
      bpc_cnt_d = '0;
      znz_cnt_d = '0;
    end else begin
      if (bpc_xfer && (bpc_cnt_q != CNT_MAX)) bpc_cnt_d = bpc_cnt_q + CNT_W'(1);
      if (znz_xfer && (znz_cnt_q != CNT_MAX)) znz_cnt_d = znz_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_RUN: begin
        if (bus.flush_i) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (trl_xfer) begin
          state_d      = ST_RUN;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
      ptr_q        <= 1'b1;
      burst_q      <= '0;
      vld_q        <= 1'b0;
      data_q       <= '0;
      src_q        <= SRC_BPC;
      last_q       <= 1'b0;
      bpc_cnt_q    <= '0;
      znz_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      ptr_q        <= ptr_d;
      burst_q      <= burst_d;
      vld_q        <= vld_d;
      data_q       <= data_d;
      src_q        <= src_d;
      last_q       <= last_d;
      bpc_cnt_q    <= bpc_cnt_d;
      znz_cnt_q    <= znz_cnt_d;
    end
  end

  assign bus.vld_o     = vld_q;
  assign bus.data_o    = data_q;
  assign bus.src_o     = src_q;
  assign bus.last_o    = last_q;
  assign bus.bpc_cnt_o = bpc_cnt_q;
  assign bus.znz_cnt_o = znz_cnt_q;
  assign bus.idle_o    = (state_q == ST_RUN) && !vld_q && !flush_pend_q &&
                         bus.bpc_idle_i && bus.znz_idle_i &&
                         !bus.bpc_vld_i && !bus.znz_vld_i;
endmodule

// File: tb/tb_ebpc_stream_arbiter.sv
// Directed bench for ebpc_stream_arbiter: per-source scoreboards, output
// stability, counter tracking, trailer placement and mid-frame reset.
module tb_ebpc_stream_arbiter;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ebpc_stream_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  ebpc_stream_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4), .CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] bpc_send[$], bpc_exp[$], znz_send[$], znz_exp[$];
  int         src_log[$];

  bit   rand_rdy = 0, rdy_fix = 1, flush_req = 0;
  int   trailers = 0;
  int   m_bpc_cnt = 0, m_znz_cnt = 0;
  int   trl_bpc_cnt = 0, trl_znz_cnt = 0;
  bit   ld_pend = 0;
  logic [7:0] ld_data;
  logic [1:0] ld_src;
  bit   stall_prev = 0, idle_chk = 0;
  logic [7:0] p_data;
  logic [1:0] p_src;
  logic       p_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bpc(input logic [7:0] d);
    bpc_send.push_back(d); bpc_exp.push_back(d);
  endtask

  task automatic push_znz(input logic [7:0] d);
    znz_send.push_back(d); znz_exp.push_back(d);
  endtask

  task automatic model_reset();
    bpc_send.delete(); bpc_exp.delete(); znz_send.delete(); znz_exp.delete();
    m_bpc_cnt = 0; m_znz_cnt = 0;
    ld_pend = 0; stall_prev = 0; idle_chk = 0;
  endtask

  // One clock: drive after the edge, sample and score on the falling edge.
  task automatic step();
    logic [7:0] e;
    bus.bpc_vld_i  = (bpc_send.size() != 0);
    bus.bpc_data_i = (bpc_send.size() != 0) ? bpc_send[0] : 8'h00;
    bus.znz_vld_i  = (znz_send.size() != 0);
    bus.znz_data_i = (znz_send.size() != 0) ? znz_send[0] : 8'h00;
    bus.rdy_i      = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    bus.flush_i    = flush_req;
    @(negedge clk_i);
    chk("rdy_exclusive", 32'(bus.bpc_rdy_o && bus.znz_rdy_o), 0);
    chk("bpc_cnt", 32'(bus.bpc_cnt_o), 32'(m_bpc_cnt));
    chk("znz_cnt", 32'(bus.znz_cnt_o), 32'(m_znz_cnt));
    if (ld_pend) begin
      chk("latency_vld", 32'(bus.vld_o), 1);
      chk("latency_data", 32'(bus.data_o), 32'(ld_data));
      chk("latency_src", 32'(bus.src_o), 32'(ld_src));
    end
    if (stall_prev) begin
      chk("stall_vld", 32'(bus.vld_o), 1);
      chk("stall_data", 32'(bus.data_o), 32'(p_data));
      chk("stall_src", 32'(bus.src_o), 32'(p_src));
      chk("stall_last", 32'(bus.last_o), 32'(p_last));
    end
    if (idle_chk) chk("idle_after_trailer", 32'(bus.idle_o), 1);
    idle_chk = 0;
    if (bus.vld_o && bus.rdy_i) begin
      src_log.push_back(int'(bus.src_o));
      if (bus.src_o == 2'b10) begin
        chk("trl_data", 32'(bus.data_o), 0);
        chk("trl_last", 32'(bus.last_o), 1);
        chk("trl_after_words", 32'(bpc_exp.size() + znz_exp.size()), 0);
        trl_bpc_cnt = int'(bus.bpc_cnt_o);
        trl_znz_cnt = int'(bus.znz_cnt_o);
        trailers++;
        m_bpc_cnt = 0; m_znz_cnt = 0;
        idle_chk = 1;
      end else begin
        chk("word_last", 32'(bus.last_o), 0);
        if (bus.src_o == 2'b00) begin
          chk("bpc_exp_avail", 32'(bpc_exp.size() != 0), 1);
          if (bpc_exp.size() != 0) begin
            e = bpc_exp.pop_front();
            chk("bpc_data", 32'(bus.data_o), 32'(e));
          end
        end else begin
          chk("znz_src", 32'(bus.src_o), 1);
          chk("znz_exp_avail", 32'(znz_exp.size() != 0), 1);
          if (znz_exp.size() != 0) begin
            e = znz_exp.pop_front();
            chk("znz_data", 32'(bus.data_o), 32'(e));
          end
        end
      end
    end
    ld_pend = 0;
    if (bus.bpc_vld_i && bus.bpc_rdy_o) begin
      void'(bpc_send.pop_front());
      m_bpc_cnt++; ld_pend = 1; ld_data = bus.bpc_data_i; ld_src = 2'b00;
    end else if (bus.znz_vld_i && bus.znz_rdy_o) begin
      void'(znz_send.pop_front());
      m_znz_cnt++; ld_pend = 1; ld_data = bus.znz_data_i; ld_src = 2'b01;
    end
    stall_prev = bus.vld_o && !bus.rdy_i;
    p_data = bus.data_o; p_src = bus.src_o; p_last = bus.last_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (bpc_exp.size() + znz_exp.size()) != 0; i++) step();
    chk("drain_left", 32'(bpc_exp.size() + znz_exp.size()), 0);
  endtask

  task automatic wait_trailer(input int budget);
    int t0 = trailers;
    for (int i = 0; i < budget && trailers == t0; i++) step();
    chk("trailer_seen", 32'(trailers - t0), 1);
  endtask

  task automatic do_flush();
    flush_req = 1; step(); flush_req = 0;
    wait_trailer(60);
    step();
  endtask

  initial begin
    int t0;
    bus.bpc_data_i = '0; bus.bpc_vld_i = 0; bus.bpc_idle_i = 1;
    bus.znz_data_i = '0; bus.znz_vld_i = 0; bus.znz_idle_i = 1;
    bus.flush_i = 0; bus.rdy_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_vld", 32'(bus.vld_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    chk("rst_src", 32'(bus.src_o), 0);
    chk("rst_last", 32'(bus.last_o), 0);
    chk("rst_bpc_cnt", 32'(bus.bpc_cnt_o), 0);
    chk("rst_znz_cnt", 32'(bus.znz_cnt_o), 0);
    chk("rst_idle", 32'(bus.idle_o), 1);
    rst_ni = 1;

    // Both sources saturated: BPC x4, ZNZ x4, ... starting with BPC.
    src_log.delete();
    for (int i = 0; i < 12; i++) begin
      push_bpc(8'(8'h10 + i)); push_znz(8'(8'h80 + i));
    end
    drain(100);
    chk("rr_len", 32'(src_log.size()), 24);
    for (int i = 0; i < 24 && i < src_log.size(); i++)
      chk($sformatf("rr_src_%0d", i), 32'(src_log[i]), 32'((i / 4) % 2));
    do_flush();

    // BPC-only stream 0x01..0x0A.
    for (int i = 1; i <= 10; i++) push_bpc(8'(i));
    drain(50);
    chk("bpc_only_cnt", 32'(bus.bpc_cnt_o), 10);
    chk("bpc_only_znz_cnt", 32'(bus.znz_cnt_o), 0);
    do_flush();
    chk("post_flush_cnt", 32'(bus.bpc_cnt_o), 0);

    // Random backpressure with both sources valid.
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      push_bpc(8'($urandom_range(0, 255))); push_znz(8'($urandom_range(0, 255)));
    end
    drain(400);
    do_flush();
    rand_rdy = 0;

    // Flush with ZNZ still busy: trailer must wait for znz_idle_i.
    push_bpc(8'h31); push_bpc(8'h32); push_bpc(8'h33);
    push_znz(8'h41); push_znz(8'h42);
    bus.znz_idle_i = 0;
    t0 = trailers;
    flush_req = 1; step(); flush_req = 0;
    repeat (4) step();
    chk("no_early_trailer", 32'(trailers - t0), 0);
    bus.znz_idle_i = 1;
    wait_trailer(30);
    chk("trl_bpc_cnt", 32'(trl_bpc_cnt), 3);
    chk("trl_znz_cnt", 32'(trl_znz_cnt), 2);
    step();
    chk("after_trl_bpc_cnt", 32'(bus.bpc_cnt_o), 0);
    chk("after_trl_znz_cnt", 32'(bus.znz_cnt_o), 0);

    // Two back-to-back flush pulses on an empty frame: one trailer.
    t0 = trailers;
    flush_req = 1; step(); step(); flush_req = 0;
    wait_trailer(30);
    repeat (8) step();
    chk("single_trailer", 32'(trailers - t0), 1);

    // Reset while a word is held and the FSM is draining.
    rdy_fix = 0;
    push_bpc(8'h51); push_bpc(8'h52); push_bpc(8'h53);
    step();
    flush_req = 1; step(); flush_req = 0;
    step();
    chk("pre_rst_vld", 32'(bus.vld_o), 1);
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_vld", 32'(bus.vld_o), 0);
    chk("mid_rst_bpc_cnt", 32'(bus.bpc_cnt_o), 0);
    chk("mid_rst_data", 32'(bus.data_o), 0);
    model_reset();
    rdy_fix = 1;
    @(posedge clk_i); #1;
    step();
    rst_ni = 1;
    step();
    chk("post_rst_idle", 32'(bus.idle_o), 1);
    src_log.delete();
    push_bpc(8'h61); push_znz(8'h71);
    drain(20);
    chk("post_rst_len", 32'(src_log.size()), 2);
    if (src_log.size() != 0) chk("post_rst_first_bpc", 32'(src_log[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
